// File: rtl/qdec_arith_ctrl_if.sv
// ---------------------------------------------------------------------------
// qdec_arith_ctrl_if
// Bin request / response bundle between the de-binarization FSMs (master)
// and the arithmetic-decoder sequencer (slave).
//   bin_req_vld/rdy     request handshake
//   bin_req_ctxIdx      context index (ignored for bypass bins)
//   bin_req_bypass      1 = equiprobable bin
//   bin_rsp_vld/rdy     response handshake
//   bin_rsp_val         decoded bin
//   bin_rsp_bytealign   decoder byte-align flag captured with the bin
// ---------------------------------------------------------------------------
interface qdec_arith_ctrl_if #(parameter int CTX_AW = 9);
    logic              bin_req_vld;
    logic              bin_req_rdy;
    logic [CTX_AW-1:0] bin_req_ctxIdx;
    logic              bin_req_bypass;
    logic              bin_rsp_vld;
    logic              bin_rsp_rdy;
    logic              bin_rsp_val;
    logic              bin_rsp_bytealign;

    modport master (
        output bin_req_vld, bin_req_ctxIdx, bin_req_bypass, bin_rsp_rdy,
        input  bin_req_rdy, bin_rsp_vld, bin_rsp_val, bin_rsp_bytealign
    );

    modport slave (
        input  bin_req_vld, bin_req_ctxIdx, bin_req_bypass, bin_rsp_rdy,
        output bin_req_rdy, bin_rsp_vld, bin_rsp_val, bin_rsp_bytealign
    );
endinterface

// File: rtl/qdec_arith_ctrl.sv
// ---------------------------------------------------------------------------
// qdec_arith_ctrl
// Sequencer in front of the CABAC arithmetic decoder. Initializes the engine
// on slice_start, then serves one bin request at a time: context bins read
// their state from context memory, run the decoder and write back the
// updated {mps, state}; bypass bins run the decoder in EP mode. Each decoded
// bin is returned on a valid/ready response.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   slice_start           pulse: abort in-flight bin, re-initialize engine
//   init_done             engine initialized, requests accepted
//   bin_if (slave)        bin request / response handshakes
//   ctx_rd_*              context memory read (data one cycle after en)
//   ctx_wr_*              context write-back
//   ad_*                  arithmetic decoder control / status
//   stat_ctx_bins/stat_ep_bins  (QDEC_ARITH_CTRL_STAT_EN only) saturating
//                         counts of responded context / bypass bins
//
// Optional feature macro: QDEC_ARITH_CTRL_STAT_EN
// All outputs are registered and are 0 during reset.
// ---------------------------------------------------------------------------
module qdec_arith_ctrl #(
    parameter int CTX_AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slice_start,
    output logic              init_done,
    qdec_arith_ctrl_if.slave  bin_if,
    output logic              ctx_rd_en,
    output logic [CTX_AW-1:0] ctx_rd_addr,
    input  logic [6:0]        ctx_rd_data,
    output logic              ctx_wr_en,
    output logic [CTX_AW-1:0] ctx_wr_addr,
    output logic [6:0]        ctx_wr_data,
    output logic              ad_EPMode,
    output logic              ad_mps,
    output logic              ad_arithInit,
    output logic              ad_dec_run,
    output logic [5:0]        ad_ctxState,
    output logic              ad_ctxState_vld,
    input  logic              ad_ctxState_rdy,
    input  logic              ad_dec_rdy,
    input  logic              ad_ruiBin,
    input  logic              ad_ruiBin_vld,
    input  logic              ad_ruiBin_bytealign,
    input  logic              ad_ctxStateUpdate_vld,
    input  logic [5:0]        ad_ctxStateUpdate,
    output logic              ad_ruiBin_rdy,
    output logic              ad_ctxStateUpdate_rdy
`ifdef QDEC_ARITH_CTRL_STAT_EN
    ,
    output logic [31:0]       stat_ctx_bins,
    output logic [31:0]       stat_ep_bins
`endif
);

    typedef enum logic [3:0] {
        IDLE, INIT_WAIT, INIT_SETTLE, READY, CTX_RD,
        CTX_LAT, CTX_RUN, EP_RUN, BIN_WAIT, RSP
    } state_t;

    state_t     state, nxt;
    logic       settle_cnt;
    logic       bypass_q;
    logic [6:0] ctx_q;

    logic req_hs, rsp_hs, run_fire, bin_cap, mps_n;

    // The decoder neither back-pressures the context state nor qualifies
    // the update separately from ad_ruiBin_vld, so these are not needed.
    logic unused_in;
    assign unused_in = ad_ctxState_rdy ^ ad_ctxStateUpdate_vld;

    assign req_hs = (state == READY) && bin_if.bin_req_vld;
    assign rsp_hs = (state == RSP) && bin_if.bin_rsp_rdy;

    // ad_dec_run doubles as the "already fired" flag: the run cycle itself
    // is spent in CTX_RUN/EP_RUN so the context state is still presented.
    assign run_fire = ((state == CTX_RUN) || (state == EP_RUN)) && !ad_dec_run
                      && ad_dec_rdy && !slice_start;
    assign bin_cap  = (state == BIN_WAIT) && ad_ruiBin_vld && !slice_start;

    // LPS decoded in state 0 swaps the MPS.
    assign mps_n = ctx_q[6] ^ ((ad_ruiBin != ctx_q[6]) && (ctx_q[5:0] == 6'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (slice_start) begin
            nxt = INIT_WAIT;
        end else begin
            case (state)
                IDLE:        nxt = IDLE;
                INIT_WAIT:   if (ad_dec_rdy) nxt = INIT_SETTLE;
                INIT_SETTLE: if (settle_cnt) nxt = READY;
                READY:       if (req_hs) nxt = bin_if.bin_req_bypass ? EP_RUN : CTX_RD;
                CTX_RD:      nxt = CTX_LAT;
                CTX_LAT:     nxt = CTX_RUN;
                CTX_RUN,
                EP_RUN:      if (ad_dec_run) nxt = BIN_WAIT;
                BIN_WAIT:    if (ad_ruiBin_vld) nxt = RSP;
                RSP:         if (bin_if.bin_rsp_rdy) nxt = READY;
                default:     nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt               <= 1'b0;
            bypass_q                 <= 1'b0;
            ctx_q                    <= '0;
            init_done                <= 1'b0;
            bin_if.bin_req_rdy       <= 1'b0;
            bin_if.bin_rsp_vld       <= 1'b0;
            bin_if.bin_rsp_val       <= 1'b0;
            bin_if.bin_rsp_bytealign <= 1'b0;
            ctx_rd_en                <= 1'b0;
            ctx_rd_addr              <= '0;
            ctx_wr_en                <= 1'b0;
            ctx_wr_addr              <= '0;
            ctx_wr_data              <= '0;
            ad_EPMode                <= 1'b0;
            ad_mps                   <= 1'b0;
            ad_arithInit             <= 1'b0;
            ad_dec_run               <= 1'b0;
            ad_ctxState              <= '0;
            ad_ctxState_vld          <= 1'b0;
            ad_ruiBin_rdy            <= 1'b0;
            ad_ctxStateUpdate_rdy    <= 1'b0;
        end else begin
            settle_cnt         <= (state == INIT_SETTLE) && !slice_start && !settle_cnt;
            init_done          <= nxt inside {READY, CTX_RD, CTX_LAT, CTX_RUN, EP_RUN, BIN_WAIT, RSP};
            bin_if.bin_req_rdy <= (nxt == READY);
            bin_if.bin_rsp_vld <= (nxt == RSP);
            ctx_rd_en          <= (nxt == CTX_RD);
            // The init pulse lands in the first INIT_SETTLE cycle, so
            // init_done follows it by two cycles.
            ad_arithInit       <= (state == INIT_WAIT) && (nxt == INIT_SETTLE);
            ad_dec_run         <= run_fire;
            ad_ruiBin_rdy      <= nxt inside {CTX_RUN, EP_RUN, BIN_WAIT};
            ad_ctxStateUpdate_rdy <= 1'b1;

            if (req_hs && !slice_start) begin
                ctx_rd_addr <= bin_if.bin_req_ctxIdx;
                bypass_q    <= bin_if.bin_req_bypass;
            end

            if (state == CTX_LAT) ctx_q <= ctx_rd_data;

            // ctx_q is not yet loaded on the CTX_LAT->CTX_RUN edge.
            ad_ctxState_vld <= (nxt == CTX_RUN);
            if (nxt == CTX_RUN) begin
                ad_ctxState <= (state == CTX_LAT) ? ctx_rd_data[5:0] : ctx_q[5:0];
                ad_mps      <= (state == CTX_LAT) ? ctx_rd_data[6]   : ctx_q[6];
            end else begin
                ad_ctxState <= '0;
                ad_mps      <= 1'b0;
            end

            // bypass_q is latched on the same edge that enters EP_RUN.
            ad_EPMode <= (nxt == EP_RUN) || (bypass_q && (nxt inside {BIN_WAIT, RSP}));

            ctx_wr_en <= bin_cap && !bypass_q;
            if (bin_cap) begin
                bin_if.bin_rsp_val       <= ad_ruiBin;
                bin_if.bin_rsp_bytealign <= ad_ruiBin_bytealign;
                if (!bypass_q) begin
                    ctx_wr_addr <= ctx_rd_addr;
                    ctx_wr_data <= {mps_n, ad_ctxStateUpdate};
                end
            end
        end
    end

`ifdef QDEC_ARITH_CTRL_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ctx_bins <= '0;
            stat_ep_bins  <= '0;
        end else if (slice_start) begin
            stat_ctx_bins <= '0;
            stat_ep_bins  <= '0;
        end else if (rsp_hs) begin
            if (!bypass_q && (stat_ctx_bins != 32'hFFFF_FFFF))
                stat_ctx_bins <= stat_ctx_bins + 32'd1;
            if (bypass_q && (stat_ep_bins != 32'hFFFF_FFFF))
                stat_ep_bins <= stat_ep_bins + 32'd1;
        end
    end
`else
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_qdec_arith_ctrl.sv
module tb_qdec_arith_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       slice_start;
    logic       init_done;
    logic       ctx_rd_en, ctx_wr_en;
    logic [8:0] ctx_rd_addr, ctx_wr_addr;
    logic [6:0] ctx_rd_data, ctx_wr_data;
    logic       ad_EPMode, ad_mps, ad_arithInit, ad_dec_run, ad_ctxState_vld;
    logic [5:0] ad_ctxState;
    logic       ad_ctxState_rdy, ad_dec_rdy, ad_ruiBin, ad_ruiBin_vld, ad_ruiBin_bytealign;
    logic       ad_ctxStateUpdate_vld;
    logic [5:0] ad_ctxStateUpdate;
    logic       ad_ruiBin_rdy, ad_ctxStateUpdate_rdy;
`ifdef QDEC_ARITH_CTRL_STAT_EN
    logic [31:0] stat_ctx_bins, stat_ep_bins;
`endif

    qdec_arith_ctrl_if #(.CTX_AW(9)) bif();

    qdec_arith_ctrl #(.CTX_AW(9)) dut (
        .clk(clk), .rst_n(rst_n), .slice_start(slice_start), .init_done(init_done),
        .bin_if(bif),
        .ctx_rd_en(ctx_rd_en), .ctx_rd_addr(ctx_rd_addr), .ctx_rd_data(ctx_rd_data),
        .ctx_wr_en(ctx_wr_en), .ctx_wr_addr(ctx_wr_addr), .ctx_wr_data(ctx_wr_data),
        .ad_EPMode(ad_EPMode), .ad_mps(ad_mps), .ad_arithInit(ad_arithInit),
        .ad_dec_run(ad_dec_run), .ad_ctxState(ad_ctxState), .ad_ctxState_vld(ad_ctxState_vld),
        .ad_ctxState_rdy(ad_ctxState_rdy), .ad_dec_rdy(ad_dec_rdy), .ad_ruiBin(ad_ruiBin),
        .ad_ruiBin_vld(ad_ruiBin_vld), .ad_ruiBin_bytealign(ad_ruiBin_bytealign),
        .ad_ctxStateUpdate_vld(ad_ctxStateUpdate_vld), .ad_ctxStateUpdate(ad_ctxStateUpdate),
        .ad_ruiBin_rdy(ad_ruiBin_rdy), .ad_ctxStateUpdate_rdy(ad_ctxStateUpdate_rdy)
`ifdef QDEC_ARITH_CTRL_STAT_EN
        , .stat_ctx_bins(stat_ctx_bins), .stat_ep_bins(stat_ep_bins)
`endif
    );

    always #5 clk = ~clk;

    // context memory model: read data one cycle after ctx_rd_en
    logic [6:0] mem [0:511];
    always @(posedge clk) if (ctx_rd_en) ctx_rd_data <= mem[ctx_rd_addr];

    // event counters sampled at the active edge
    int n_init = 0, n_run = 0, n_rd = 0, n_wr = 0, n_rspv = 0;
    always @(posedge clk) begin
        if (ad_arithInit)    n_init <= n_init + 1;
        if (ad_dec_run)      n_run  <= n_run + 1;
        if (ctx_rd_en)       n_rd   <= n_rd + 1;
        if (ctx_wr_en)       n_wr   <= n_wr + 1;
        if (bif.bin_rsp_vld) n_rspv <= n_rspv + 1;
    end

    int n_tests = 0, n_fail = 0;

    // results recorded by run_bin (cycle indices relative to handshake cycle 0)
    int rd_k, run_k, v_k, rsp_k, hs_k;
    logic epm_run, rsp_val_s, ba_s, wr_en_s, rdy_after, tmo;
    logic [8:0] wr_addr_s;
    logic [6:0] wr_data_s;

    // Issues one request and plays the decoder: ad_dec_rdy low for rdy_low
    // cycles from the handshake, ad_ruiBin_vld two cycles after the run
    // pulse, bin_rsp_rdy held low rsp_hold cycles after bin_rsp_vld rises.
    task automatic run_bin(input logic [8:0] idx, input logic byp, input logic b,
                           input logic [5:0] upd, input logic ba,
                           input int rdy_low, input int rsp_hold);
        int w;
        bit done;
        rd_k = -1; run_k = -1; v_k = -1; rsp_k = -1; hs_k = -1;
        epm_run = 0; rsp_val_s = 0; ba_s = 0; wr_en_s = 0; rdy_after = 0; tmo = 0;
        wr_addr_s = 0; wr_data_s = 0;
        w = 0;
        while (bif.bin_req_rdy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if (bif.bin_req_rdy !== 1'b1) begin tmo = 1; return; end
        bif.bin_req_vld = 1; bif.bin_req_ctxIdx = idx; bif.bin_req_bypass = byp;
        if (rdy_low > 0) ad_dec_rdy = 0;
        done = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            bif.bin_req_vld = 0;
            ad_ruiBin_vld = 0; ad_ctxStateUpdate_vld = 0;
            if (hs_k > 0) begin
                rdy_after = bif.bin_req_rdy;
                bif.bin_rsp_rdy = 0;
                done = 1;
            end else begin
                if (rdy_low > 0 && k == rdy_low) ad_dec_rdy = 1;
                if (ctx_rd_en && rd_k < 0) rd_k = k;
                if (ad_dec_run && run_k < 0) begin run_k = k; epm_run = ad_EPMode; end
                if (run_k > 0 && k == run_k + 2) begin
                    ad_ruiBin_vld = 1; ad_ruiBin = b; ad_ruiBin_bytealign = ba;
                    ad_ctxStateUpdate = upd; ad_ctxStateUpdate_vld = 1; v_k = k;
                end
                if (bif.bin_rsp_vld && rsp_k < 0) begin
                    rsp_k = k; rsp_val_s = bif.bin_rsp_val; ba_s = bif.bin_rsp_bytealign;
                    wr_en_s = ctx_wr_en; wr_addr_s = ctx_wr_addr; wr_data_s = ctx_wr_data;
                end
                if (rsp_k > 0 && k >= rsp_k + rsp_hold) bif.bin_rsp_rdy = 1;
                if (bif.bin_rsp_vld && bif.bin_rsp_rdy) hs_k = k;
            end
        end
        if (!done) tmo = 1;
        bif.bin_rsp_rdy = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({init_done, bif.bin_req_rdy, bif.bin_rsp_vld, ctx_rd_en, ctx_wr_en, ad_EPMode,
             ad_mps, ad_arithInit, ad_dec_run, ad_ctxState_vld, ad_ruiBin_rdy,
             ad_ctxStateUpdate_rdy} !== 12'h0) begin
            n_fail++; $display("FAIL reset_ctrl: ctrl outputs not all 0 during reset");
        end
        n_tests++;
        if ({ctx_wr_data, ad_ctxState, ctx_rd_addr, ctx_wr_addr} !== 31'h0) begin
            n_fail++; $display("FAIL reset_data: data outputs not all 0 during reset");
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({init_done, bif.bin_req_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 00", {init_done, bif.bin_req_rdy});
        end
        n_tests++;
        if (ad_ctxStateUpdate_rdy !== 1'b1) begin
            n_fail++; $display("FAIL upd_rdy: got %b want 1", ad_ctxStateUpdate_rdy);
        end
    endtask

    task automatic test_init;
        int np, pk, dk;
        np = 0; pk = -1; dk = -1;
        ad_dec_rdy = 0;
        slice_start = 1;
        @(negedge clk); slice_start = 0;
        @(negedge clk);
        @(negedge clk); ad_dec_rdy = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ad_arithInit) begin np++; if (pk < 0) pk = k; end
            if (init_done && dk < 0) dk = k;
        end
        n_tests++;
        if (np !== 1) begin n_fail++; $display("FAIL init_pulses: got %0d want 1", np); end
        n_tests++;
        if (dk - pk !== 2) begin
            n_fail++; $display("FAIL init_done_delay: got %0d want 2 (pulse %0d done %0d)", dk - pk, pk, dk);
        end
        n_tests++;
        if (bif.bin_req_rdy !== 1'b1) begin n_fail++; $display("FAIL ready_after_init: got %b want 1", bif.bin_req_rdy); end
    endtask

    task automatic test_ignore_vld;
        logic bad_rsp, bad_rdy;
        bad_rsp = 0; bad_rdy = 0;
        ad_ruiBin_vld = 1; ad_ruiBin = 1;
        @(negedge clk); ad_ruiBin_vld = 0;
        for (int k = 0; k < 3; k++) begin
            if (bif.bin_rsp_vld !== 1'b0) bad_rsp = 1;
            if (bif.bin_req_rdy !== 1'b1) bad_rdy = 1;
            @(negedge clk);
        end
        n_tests++;
        if (bad_rsp !== 1'b0) begin n_fail++; $display("FAIL stray_vld_rsp: got rsp_vld 1 want 0"); end
        n_tests++;
        if (bad_rdy !== 1'b0) begin n_fail++; $display("FAIL stray_vld_rdy: got req_rdy 0 want 1"); end
    endtask

    task automatic test_ctx_lps_state0;
        int wr0, run0;
        wr0 = n_wr; run0 = n_run;
        run_bin(9'd5, 1'b0, 1'b0, 6'd0, 1'b0, 0, 0);
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ctx5_timeout: got %b want 0", tmo); end
        n_tests++; if (rd_k !== 1) begin n_fail++; $display("FAIL ctx5_rd_time: got %0d want 1", rd_k); end
        n_tests++; if ((run_k >= 3) !== 1'b1) begin n_fail++; $display("FAIL ctx5_run_time: got %0d want >=3", run_k); end
        n_tests++; if (rsp_k !== v_k + 1) begin n_fail++; $display("FAIL ctx5_rsp_time: got %0d want %0d", rsp_k, v_k + 1); end
        n_tests++; if (wr_en_s !== 1'b1) begin n_fail++; $display("FAIL ctx5_wr_en: got %b want 1", wr_en_s); end
        n_tests++; if (wr_addr_s !== 9'd5) begin n_fail++; $display("FAIL ctx5_wr_addr: got %0d want 5", wr_addr_s); end
        n_tests++; if (wr_data_s !== 7'h00) begin n_fail++; $display("FAIL ctx5_wr_data: got %h want 00", wr_data_s); end
        n_tests++; if (rsp_val_s !== 1'b0) begin n_fail++; $display("FAIL ctx5_bin: got %b want 0", rsp_val_s); end
        n_tests++; if (n_wr - wr0 !== 1) begin n_fail++; $display("FAIL ctx5_wr_count: got %0d want 1", n_wr - wr0); end
        n_tests++; if (n_run - run0 !== 1) begin n_fail++; $display("FAIL ctx5_run_count: got %0d want 1", n_run - run0); end
        n_tests++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL ctx5_b2b_rdy: got %b want 1", rdy_after); end
    endtask

    task automatic test_ctx_update;
        run_bin(9'd12, 1'b0, 1'b0, 6'd21, 1'b0, 0, 0);
        n_tests++; if (rd_k !== 1) begin n_fail++; $display("FAIL ctx12_rd_time: got %0d want 1", rd_k); end
        n_tests++; if (wr_addr_s !== 9'd12) begin n_fail++; $display("FAIL ctx12_wr_addr: got %0d want 12", wr_addr_s); end
        n_tests++; if (wr_data_s !== 7'd21) begin n_fail++; $display("FAIL ctx12_wr_data: got %h want 15", wr_data_s); end
        n_tests++; if (rsp_val_s !== 1'b0) begin n_fail++; $display("FAIL ctx12_bin: got %b want 0", rsp_val_s); end
    endtask

    task automatic test_ctx_mps_flip;
        run_bin(9'd7, 1'b0, 1'b1, 6'd3, 1'b1, 0, 0);
        n_tests++; if (wr_data_s !== 7'h43) begin n_fail++; $display("FAIL ctx7_wr_data: got %h want 43", wr_data_s); end
        n_tests++; if (rsp_val_s !== 1'b1) begin n_fail++; $display("FAIL ctx7_bin: got %b want 1", rsp_val_s); end
        n_tests++; if (ba_s !== 1'b1) begin n_fail++; $display("FAIL ctx7_bytealign: got %b want 1", ba_s); end
    endtask

    task automatic test_bypass;
        int rd0, wr0, run0;
        rd0 = n_rd; wr0 = n_wr; run0 = n_run;
        run_bin(9'd9, 1'b1, 1'b1, 6'd0, 1'b1, 4, 0);
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ep_timeout: got %b want 0", tmo); end
        n_tests++; if (run_k !== 5) begin n_fail++; $display("FAIL ep_run_time: got %0d want 5", run_k); end
        n_tests++; if (n_run - run0 !== 1) begin n_fail++; $display("FAIL ep_run_count: got %0d want 1", n_run - run0); end
        n_tests++; if (epm_run !== 1'b1) begin n_fail++; $display("FAIL ep_mode_at_run: got %b want 1", epm_run); end
        n_tests++; if (n_rd - rd0 !== 0) begin n_fail++; $display("FAIL ep_rd_count: got %0d want 0", n_rd - rd0); end
        n_tests++; if (n_wr - wr0 !== 0) begin n_fail++; $display("FAIL ep_wr_count: got %0d want 0", n_wr - wr0); end
        n_tests++; if (rsp_val_s !== 1'b1) begin n_fail++; $display("FAIL ep_bin: got %b want 1", rsp_val_s); end
        n_tests++; if (rsp_k !== v_k + 1) begin n_fail++; $display("FAIL ep_rsp_time: got %0d want %0d", rsp_k, v_k + 1); end
        n_tests++; if (ad_EPMode !== 1'b0) begin n_fail++; $display("FAIL ep_mode_after: got %b want 0", ad_EPMode); end
    endtask

    task automatic test_back_to_back;
        int wr0, rsp0;
        wr0 = n_wr; rsp0 = n_rspv;
        // state 20 is nonzero, so an LPS keeps mps=0
        run_bin(9'd12, 1'b0, 1'b1, 6'd19, 1'b0, 0, 3);
        n_tests++; if (hs_k - rsp_k !== 3) begin n_fail++; $display("FAIL b2b_hold: got %0d want 3", hs_k - rsp_k); end
        n_tests++; if (wr_data_s !== 7'd19) begin n_fail++; $display("FAIL b2b_wr_data: got %h want 13", wr_data_s); end
        n_tests++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy1: got %b want 1", rdy_after); end
        run_bin(9'd0, 1'b1, 1'b0, 6'd0, 1'b0, 0, 0);
        n_tests++; if (rsp_val_s !== 1'b0) begin n_fail++; $display("FAIL b2b_ep_bin: got %b want 0", rsp_val_s); end
        n_tests++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy2: got %b want 1", rdy_after); end
        n_tests++; if (n_wr - wr0 !== 1) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 1", n_wr - wr0); end
        n_tests++; if (n_rspv - rsp0 !== 5) begin n_fail++; $display("FAIL b2b_rsp_cycles: got %0d want 5", n_rspv - rsp0); end
    endtask

    task automatic test_slice_abort;
        int wr0, rsp0, init0, rk, dk;
        logic [2:0] flags;
        wr0 = n_wr; rsp0 = n_rspv; init0 = n_init; rk = -1; dk = -1;
        bif.bin_req_vld = 1; bif.bin_req_ctxIdx = 9'd5; bif.bin_req_bypass = 0;
        for (int k = 1; k <= 20 && rk < 0; k++) begin
            @(negedge clk);
            bif.bin_req_vld = 0;
            if (ad_dec_run) rk = k;
        end
        n_tests++; if (rk < 0) begin n_fail++; $display("FAIL abort_run_seen: got none want run pulse"); end
        @(negedge clk);              // now in BIN_WAIT
        slice_start = 1;
        @(negedge clk);
        slice_start = 0;
        flags = {init_done, bif.bin_req_rdy, bif.bin_rsp_vld};
        ad_ruiBin_vld = 1; ad_ruiBin = 1; ad_ctxStateUpdate = 6'd9; ad_ctxStateUpdate_vld = 1;
        @(negedge clk);
        ad_ruiBin_vld = 0; ad_ctxStateUpdate_vld = 0;
        n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b want 000", flags); end
        for (int k = 1; k <= 20 && dk < 0; k++) begin
            @(negedge clk);
            if (init_done) dk = k;
        end
        n_tests++; if (dk < 0) begin n_fail++; $display("FAIL abort_reinit: init_done got 0 want 1"); end
        n_tests++; if (n_wr - wr0 !== 0) begin n_fail++; $display("FAIL abort_wr: got %0d want 0", n_wr - wr0); end
        n_tests++; if (n_rspv - rsp0 !== 0) begin n_fail++; $display("FAIL abort_rsp: got %0d want 0", n_rspv - rsp0); end
        n_tests++; if (n_init - init0 !== 1) begin n_fail++; $display("FAIL abort_init: got %0d want 1", n_init - init0); end
    endtask

`ifdef QDEC_ARITH_CTRL_STAT_EN
    task automatic test_stats;
        int dk;
        dk = -1;
        slice_start = 1;
        @(negedge clk); slice_start = 0;
        for (int k = 1; k <= 20 && dk < 0; k++) begin @(negedge clk); if (init_done) dk = k; end
        n_tests++; if ({stat_ctx_bins, stat_ep_bins} !== 64'h0) begin
            n_fail++; $display("FAIL stat_clear1: got %0d/%0d want 0/0", stat_ctx_bins, stat_ep_bins);
        end
        run_bin(9'd5, 1'b0, 1'b0, 6'd1, 1'b0, 0, 0);
        run_bin(9'd0, 1'b1, 1'b1, 6'd0, 1'b0, 0, 5);
        run_bin(9'd12, 1'b0, 1'b0, 6'd2, 1'b0, 0, 0);
        run_bin(9'd7, 1'b0, 1'b1, 6'd0, 1'b0, 0, 0);
        run_bin(9'd0, 1'b1, 1'b0, 6'd0, 1'b0, 0, 0);
        n_tests++; if (stat_ctx_bins !== 32'd3) begin n_fail++; $display("FAIL stat_ctx: got %0d want 3", stat_ctx_bins); end
        n_tests++; if (stat_ep_bins !== 32'd2) begin n_fail++; $display("FAIL stat_ep: got %0d want 2", stat_ep_bins); end
        slice_start = 1;
        @(negedge clk); slice_start = 0;
        n_tests++; if ({stat_ctx_bins, stat_ep_bins} !== 64'h0) begin
            n_fail++; $display("FAIL stat_clear2: got %0d/%0d want 0/0", stat_ctx_bins, stat_ep_bins);
        end
    endtask
`endif

    initial begin
        rst_n = 0; slice_start = 0;
        ad_ctxState_rdy = 1; ad_dec_rdy = 0; ad_ruiBin = 0; ad_ruiBin_vld = 0;
        ad_ruiBin_bytealign = 0; ad_ctxStateUpdate_vld = 0; ad_ctxStateUpdate = 0;
        bif.bin_req_vld = 0; bif.bin_req_ctxIdx = 0; bif.bin_req_bypass = 0; bif.bin_rsp_rdy = 0;
        for (int i = 0; i < 512; i++) mem[i] = 7'h00;
        mem[5]  = 7'h40;    // mps=1, state=0
        mem[12] = 7'd20;    // mps=0, state=20
        mem[7]  = 7'h00;    // mps=0, state=0

        test_reset();
        test_init();
        test_ignore_vld();
        test_ctx_lps_state0();
        test_ctx_update();
        test_ctx_mps_flip();
        test_bypass();
        test_back_to_back();
        test_slice_abort();
`ifdef QDEC_ARITH_CTRL_STAT_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
